// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector.
// Scans a qualified bit stream for PATTERN (MSB received first), pulses
// `detected` one cycle after the completing bit, and keeps a saturating
// match counter. Overlapping or non-overlapping detection is chosen per
// valid bit through overlap_en.
module seq_detector_param #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int                COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               overlap_en,
  output logic               detected,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat,
  output logic               busy
);

  // fill_cnt spans 0..PAT_W inclusive
  localparam int FC_W = $clog2(PAT_W + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(PAT_W);
  localparam logic [FC_W-1:0] FC_ARM = FC_W'(PAT_W - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Only the newest PAT_W-1 bits are ever compared together with the
  // incoming bit, so the oldest history bit is not stored.
  logic [PAT_W-2:0]   hist_reg;
  logic [FC_W-1:0]    fill_cnt_reg;
  state_t             state_reg;
  logic               detected_reg;
  logic [COUNT_W-1:0] match_count_reg;

  logic [PAT_W-1:0]   cand_next;
  logic [FC_W-1:0]    fill_inc_next;
  logic               match_next;
  logic               cnt_full_next;

  // Candidate window, saturating fill increment and match decode
  always_comb begin
    cand_next     = {hist_reg, in_bit};
    fill_inc_next = (fill_cnt_reg == FC_MAX) ? FC_MAX : fill_cnt_reg + FC_W'(1);
    match_next    = in_valid && (state_reg == ARMED) && (cand_next == PATTERN);
    cnt_full_next = &match_count_reg;
  end

  // History, fill counter, FSM, detect pulse and match counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg        <= '0;
      fill_cnt_reg    <= '0;
      state_reg       <= FILL;
      detected_reg    <= 1'b0;
      match_count_reg <= '0;
    end else if (clear) begin
      // A match completing in this cycle is discarded along with the rest
      hist_reg        <= '0;
      fill_cnt_reg    <= '0;
      state_reg       <= FILL;
      detected_reg    <= 1'b0;
      match_count_reg <= '0;
    end else if (in_valid) begin
      hist_reg     <= cand_next[PAT_W-2:0];
      detected_reg <= match_next;
      if (match_next) begin
        if (!cnt_full_next) begin
          match_count_reg <= match_count_reg + COUNT_W'(1);
        end
        if (overlap_en) begin
          // Trailing bits may start the next match
          fill_cnt_reg <= fill_inc_next;
          state_reg    <= ARMED;
        end else begin
          // Next match needs PAT_W fresh bits
          fill_cnt_reg <= '0;
          state_reg    <= FILL;
        end
      end else begin
        fill_cnt_reg <= fill_inc_next;
        if (fill_inc_next >= FC_ARM) begin
          state_reg <= ARMED;
        end
      end
    end else begin
      // Gaps hold everything except the one-cycle pulse
      detected_reg <= 1'b0;
    end
  end

  assign detected    = detected_reg;
  assign match_count = match_count_reg;
  assign count_sat   = &match_count_reg;
  assign busy        = (state_reg == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: two instances (COUNT_W=8 and COUNT_W=3)
// share one stimulus stream and are compared every cycle against a
// queue-based reference model of the detection rules.
module tb_seq_detector_param;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic       in_bit;
  logic       overlap_en;

  logic       det_a, sat_a, busy_a;
  logic [7:0] cnt_a;
  logic       det_b, sat_b, busy_b;
  logic [2:0] cnt_b;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PATTERN), .COUNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .overlap_en(overlap_en), .detected(det_a),
    .match_count(cnt_a), .count_sat(sat_a), .busy(busy_a)
  );

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(PATTERN), .COUNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .overlap_en(overlap_en), .detected(det_b),
    .match_count(cnt_b), .count_sat(sat_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits received since the last restart (newest at back)
  bit q[$];
  bit m_det;
  int m_cnt_a;
  int m_cnt_b;

  int n_checks;
  int n_err;
  int pulses;
  int step_no;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_det   = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Last PAT_W received bits read as a number, first-received bit as MSB
  function automatic int tail_value();
    int v;
    v = 0;
    for (int i = 0; i < PAT_W; i++) v = (v << 1) | int'(q[q.size() - PAT_W + i]);
    return v;
  endfunction

  task automatic model_update(input logic v, input logic b, input logic ov, input logic clr);
    if (clr) begin
      model_reset();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > PAT_W) void'(q.pop_front());
      m_det = (q.size() == PAT_W) && (tail_value() == int'(PATTERN));
      if (m_det) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 7)   m_cnt_b++;
        if (!ov) q.delete();
      end
    end else begin
      m_det = 1'b0;
    end
  endtask

  task automatic check_all();
    logic m_busy;
    m_busy = (q.size() >= PAT_W - 1);
    check_val("det_a",  32'(det_a),  32'(m_det));
    check_val("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
    check_val("sat_a",  32'(sat_a),  32'(m_cnt_a == 255));
    check_val("busy_a", 32'(busy_a), 32'(m_busy));
    check_val("det_b",  32'(det_b),  32'(m_det));
    check_val("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
    check_val("sat_b",  32'(sat_b),  32'(m_cnt_b == 7));
    check_val("busy_b", 32'(busy_b), 32'(m_busy));
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge
  task automatic step(input logic v, input logic b, input logic ov, input logic clr);
    in_valid   = v;
    in_bit     = b;
    overlap_en = ov;
    clear      = clr;
    @(posedge clk);
    model_update(v, b, ov, clr);
    #1;
    check_all();
    if (det_a) pulses++;
    step_no++;
    $display("step %0d v=%0b b=%0b ov=%0b clr=%0b det=%0b cnt_a=%0d cnt_b=%0d busy=%0b",
             step_no, v, b, ov, clr, det_a, cnt_a, cnt_b, busy_a);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once
  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    reset_n  = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    $display("reset applied");
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic ov, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], ov, 1'b0);
      if (i > 0) repeat (gap) step(1'b0, 1'b0, ov, 1'b0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    pulses     = 0;
    step_no    = 0;
    reset_n    = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    overlap_en = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Idle after reset
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Single non-overlapping match
    pulses = 0;
    send_bits(32'b1011, 4, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t2_pulses", 32'(pulses), 32'd1);
    check_val("t2_cnt", 32'(cnt_a), 32'd1);

    // Overlapping stream yields two matches
    step(1'b0, 1'b0, 1'b1, 1'b1);
    pulses = 0;
    send_bits(32'b1011011, 7, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t3_ov_pulses", 32'(pulses), 32'd2);
    check_val("t3_ov_cnt", 32'(cnt_a), 32'd2);

    // Same stream non-overlapping yields one
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    send_bits(32'b1011011, 7, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t3_no_pulses", 32'(pulses), 32'd1);
    check_val("t3_no_cnt", 32'(cnt_a), 32'd1);

    // Gaps between bits do not break the pattern
    for (int g = 0; g < 3; g++) begin
      int gap;
      gap = (g == 0) ? 0 : (g == 1) ? 1 : 5;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      pulses = 0;
      send_bits(32'b1011, 4, 1'b0, gap);
      check_val("t4_det_last", 32'(det_a), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("t4_pulses", 32'(pulses), 32'd1);
    end

    // Counter saturation on the narrow instance
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int k = 0; k < 9; k++) send_bits(32'b1011, 4, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t5_pulses", 32'(pulses), 32'd9);
    check_val("t5_cnt_b", 32'(cnt_b), 32'd7);
    check_val("t5_sat_b", 32'(sat_b), 32'd1);
    check_val("t5_cnt_a", 32'(cnt_a), 32'd9);

    // Clear wins over a completing match
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b101, 3, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("t6_clr_det", 32'(det_a), 32'd0);
    check_val("t6_clr_cnt", 32'(cnt_a), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("t6_clr_after", 32'(det_a), 32'd0);

    // Reset mid-pattern, and reset killing an in-flight pulse
    send_bits(32'b101, 3, 1'b0, 0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("t6_rst_det", 32'(det_a), 32'd0);
    send_bits(32'b011, 3, 1'b0, 0);
    check_val("t6_pulse", 32'(det_a), 32'd1);
    do_reset();

    // Randomised stream
    for (int n = 0; n < 1500; n++) begin
      logic v, b, ov, clr;
      v   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 2) != 0);
      ov  = ($urandom_range(0, 7) == 0) ? ~overlap_en : overlap_en;
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(v, b, ov, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
